mips_multicycle_ctrl: RTL and testbench

- Moore-style main control FSM plus ALU decoder that sequences the multi-cycle (non-pipelined) MIPS datapath.
- Drives the PC enable, instruction-register enable, register-file write, the memory/ALU mux selects and the ALU operation, from the current opcode/funct and the ALU zero flag.
- Instantiated beside the datapath inside the MIPS top level.

---
 rtl/mips_multicycle_ctrl_if.sv | 34 +++
 rtl/mips_multicycle_ctrl.sv | 155 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
interface mips_multicycle_ctrl_if #(
   parameter int OPCODE_WIDTH = 6,
   parameter int FUNCT_WIDTH  = 6
);
   logic [OPCODE_WIDTH-1:0] opcode;
   logic [FUNCT_WIDTH-1:0]  funct;
   logic                    zero;
   logic                    pc_en;
   logic                    iord;
   logic                    mem_write;
   logic                    ir_write;
   logic                    reg_dst;
   logic                    mem_to_reg;
   logic                    reg_write;
   logic                    alu_src_a;
   logic [2:0]              alu_src_b;
   logic [2:0]              alu_ctrl;
   logic [1:0]              pc_src;
   logic                    illegal_instr;
   logic [3:0]              state_o;

   modport master (
      input  opcode, funct, zero,
      output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal_instr, state_o
   );

   modport slave (
      output opcode, funct, zero,
      input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
             alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal_instr, state_o
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore main-control FSM and ALU decoder for the multi-cycle MIPS datapath.
// Optional andi/ori support is enabled by defining MIPS_CTRL_LOGIC_IMM_EN.
module mips_multicycle_ctrl #(
   parameter int OPCODE_WIDTH = 6,
   parameter int FUNCT_WIDTH  = 6
) (
   input logic                     clk,
   input logic                     rst,
   mips_multicycle_ctrl_if.master  bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
      S_BRANCH = 4'd8,  S_IEXEC  = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
      S_LEXEC  = 4'd12
   } state_t;

   localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
   localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
   localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
   localparam logic [OPCODE_WIDTH-1:0] OP_J    = OPCODE_WIDTH'(6'b000010);
   localparam logic [OPCODE_WIDTH-1:0] OP_ANDI = OPCODE_WIDTH'(6'b001100);
   localparam logic [OPCODE_WIDTH-1:0] OP_ORI  = OPCODE_WIDTH'(6'b001101);

   localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                          ALU_OR  = 3'b001, ALU_SLT = 3'b111;
   localparam logic [2:0] SRCB_B = 3'b000, SRCB_4 = 3'b001, SRCB_IMM = 3'b010,
                          SRCB_IMM_SH = 3'b011, SRCB_ZIMM = 3'b100;
   localparam logic [1:0] PCSRC_ALU = 2'b00, PCSRC_REG = 2'b01, PCSRC_JMP = 2'b10;

   // Unsupported opcodes map to FETCH, which doubles as the legality test.
   function automatic state_t op_target(input logic [OPCODE_WIDTH-1:0] op);
      case (op)
         OP_LW, OP_SW: op_target = S_MEMADR;
         OP_R:         op_target = S_EXEC;
         OP_BEQ:       op_target = S_BRANCH;
         OP_ADDI:      op_target = S_IEXEC;
         OP_J:         op_target = S_JUMP;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
         OP_ANDI, OP_ORI: op_target = S_LEXEC;
`endif
         default:      op_target = S_FETCH;
      endcase
   endfunction

   // Returns {legal, alu_ctrl} for an R-type funct field.
   function automatic logic [3:0] funct_decode(input logic [FUNCT_WIDTH-1:0] fn);
      case (fn)
         FUNCT_WIDTH'(6'b100000): funct_decode = {1'b1, ALU_ADD};
         FUNCT_WIDTH'(6'b100010): funct_decode = {1'b1, ALU_SUB};
         FUNCT_WIDTH'(6'b100100): funct_decode = {1'b1, ALU_AND};
         FUNCT_WIDTH'(6'b100101): funct_decode = {1'b1, ALU_OR};
         FUNCT_WIDTH'(6'b101010): funct_decode = {1'b1, ALU_SLT};
         default:                 funct_decode = {1'b0, ALU_ADD};
      endcase
   endfunction

   state_t                  state_q, state_d;
   logic [OPCODE_WIDTH-1:0] opcode;
   logic [FUNCT_WIDTH-1:0]  funct;
   logic [3:0]              fn_dec;
   logic                    op_legal;
   logic pc_write, branch, illegal, iord, mem_write, ir_write, reg_dst, mem_to_reg;
   logic reg_write, alu_src_a;
   logic [2:0] alu_src_b, alu_ctrl;
   logic [1:0] pc_src;

   assign opcode   = bus.opcode;
   assign funct    = bus.funct;
   assign fn_dec   = funct_decode(funct);
   assign op_legal = (op_target(opcode) != S_FETCH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = op_target(opcode);
         S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = S_MEMWB;
         S_EXEC:   state_d = fn_dec[3] ? S_ALUWB : S_FETCH;
         S_IEXEC:  state_d = S_IWB;
`ifdef MIPS_CTRL_LOGIC_IMM_EN
         S_LEXEC:  state_d = S_IWB;
`endif
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      branch     = 1'b0;
      illegal    = 1'b0;
      iord       = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_ctrl   = ALU_ADD;
      pc_src     = PCSRC_ALU;
      case (state_q)
         S_FETCH:  begin ir_write = 1'b1; alu_src_b = SRCB_4; pc_write = 1'b1; end
         S_DECODE: begin alu_src_b = SRCB_IMM_SH; illegal = ~op_legal; end
         S_MEMADR: begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
         S_MEMRD:  iord = 1'b1;
         S_MEMWB:  begin mem_to_reg = 1'b1; reg_write = 1'b1; end
         S_MEMWR:  begin iord = 1'b1; mem_write = 1'b1; end
         S_EXEC:   begin alu_src_a = 1'b1; alu_ctrl = fn_dec[2:0]; illegal = ~fn_dec[3]; end
         S_ALUWB:  begin reg_dst = 1'b1; reg_write = 1'b1; end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_ctrl  = ALU_SUB;
            pc_src    = PCSRC_REG;
            branch    = 1'b1;
         end
         S_IEXEC:  begin alu_src_a = 1'b1; alu_src_b = SRCB_IMM; end
         S_IWB:    reg_write = 1'b1;
         S_JUMP:   begin pc_src = PCSRC_JMP; pc_write = 1'b1; end
`ifdef MIPS_CTRL_LOGIC_IMM_EN
         S_LEXEC:  begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_ZIMM;
            alu_ctrl  = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
         end
`endif
         default:  ;
      endcase
   end

   // Strobes are masked while reset is held; state_q already sits in FETCH.
   assign bus.pc_en         = (pc_write | (branch & bus.zero)) & ~rst;
   assign bus.ir_write      = ir_write  & ~rst;
   assign bus.reg_write     = reg_write & ~rst;
   assign bus.mem_write     = mem_write & ~rst;
   assign bus.illegal_instr = illegal   & ~rst;
   assign bus.iord          = iord;
   assign bus.reg_dst       = reg_dst;
   assign bus.mem_to_reg    = mem_to_reg;
   assign bus.alu_src_a     = alu_src_a;
   assign bus.alu_src_b     = alu_src_b;
   assign bus.alu_ctrl      = alu_ctrl;
   assign bus.pc_src        = pc_src;
   assign bus.state_o       = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle vector table through a scoreboard, plus an async-reset sequence.
module tb_mips_multicycle_ctrl;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                          ADDI = 6'b001000, JMP = 6'b000010, ANDI = 6'b001100,
                          ORI = 6'b001101, BAD = 6'b111111;
   localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_AND = 3'b000, A_OR = 3'b001,
                          A_SLT = 3'b111;

   typedef struct packed {
      logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
      logic [2:0] alu_src_b, alu_ctrl;
      logic [1:0] pc_src;
      logic       illegal;
   } ctl_t;

   typedef struct {
      logic       rst;
      logic [5:0] op, fn;
      logic       z;
      int         st;
      logic       ill;
      logic [2:0] ac;
   } row_t;

   typedef struct {
      int   idx;
      int   st;
      ctl_t v, m;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   row_t rows[$];
   exp_t sb[$];

   mips_multicycle_ctrl_if #(.OPCODE_WIDTH(6), .FUNCT_WIDTH(6)) bus ();
   mips_multicycle_ctrl #(.OPCODE_WIDTH(6), .FUNCT_WIDTH(6)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic void add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input int st, input logic ill, input logic [2:0] ac);
      row_t x;
      x.rst = r; x.op = op; x.fn = fn; x.z = z; x.st = st; x.ill = ill; x.ac = ac;
      rows.push_back(x);
   endfunction

   // Expected outputs per state; strobes and illegal are always checked, selects only where defined.
   function automatic void model(input row_t r, output ctl_t v, output ctl_t m);
      v = '0; m = '0;
      m.pc_en = 1'b1; m.mem_write = 1'b1; m.ir_write = 1'b1; m.reg_write = 1'b1; m.illegal = 1'b1;
      case (r.st)
         0: begin
            v.ir_write = 1'b1; v.pc_en = 1'b1; v.alu_src_b = 3'b001; v.alu_ctrl = A_ADD;
            m.iord = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_ctrl = '1; m.pc_src = '1;
         end
         1: begin
            v.alu_src_b = 3'b011; v.alu_ctrl = A_ADD; v.illegal = r.ill;
            m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_ctrl = '1;
         end
         2, 9: begin
            v.alu_src_a = 1'b1; v.alu_src_b = 3'b010; v.alu_ctrl = A_ADD;
            m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_ctrl = '1;
         end
         3: begin v.iord = 1'b1; m.iord = 1'b1; end
         4: begin v.mem_to_reg = 1'b1; v.reg_write = 1'b1; m.reg_dst = 1'b1; m.mem_to_reg = 1'b1; end
         5: begin v.iord = 1'b1; v.mem_write = 1'b1; m.iord = 1'b1; end
         6: begin
            v.alu_src_a = 1'b1; v.alu_src_b = 3'b000; v.alu_ctrl = r.ac; v.illegal = r.ill;
            m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_ctrl = {3{~r.ill}};
         end
         7: begin v.reg_dst = 1'b1; v.reg_write = 1'b1; m.reg_dst = 1'b1; m.mem_to_reg = 1'b1; end
         8: begin
            v.alu_src_a = 1'b1; v.alu_ctrl = A_SUB; v.pc_src = 2'b01; v.pc_en = r.z;
            m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_ctrl = '1; m.pc_src = '1;
         end
         10: begin v.reg_write = 1'b1; m.reg_dst = 1'b1; m.mem_to_reg = 1'b1; end
         11: begin v.pc_src = 2'b10; v.pc_en = 1'b1; m.pc_src = '1; end
         12: begin
            v.alu_src_a = 1'b1; v.alu_src_b = 3'b100; v.alu_ctrl = r.ac;
            m.alu_src_a = 1'b1; m.alu_src_b = '1; m.alu_ctrl = '1;
         end
         default: ;
      endcase
      if (r.rst) begin
         v.pc_en = 1'b0; v.ir_write = 1'b0; v.reg_write = 1'b0; v.mem_write = 1'b0; v.illegal = 1'b0;
      end
   endfunction

   function automatic ctl_t get_ctl();
      ctl_t c;
      c.pc_en = bus.pc_en; c.iord = bus.iord; c.mem_write = bus.mem_write;
      c.ir_write = bus.ir_write; c.reg_dst = bus.reg_dst; c.mem_to_reg = bus.mem_to_reg;
      c.reg_write = bus.reg_write; c.alu_src_a = bus.alu_src_a; c.alu_src_b = bus.alu_src_b;
      c.alu_ctrl = bus.alu_ctrl; c.pc_src = bus.pc_src; c.illegal = bus.illegal_instr;
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_ctl(input int idx, input ctl_t act, input ctl_t exp, input ctl_t msk);
      logic [16:0] a, e, mk;
      a = act; e = exp; mk = msk;
      checks++;
      if ((a & mk) !== (e & mk)) begin
         errors++;
         $display("FAIL row%0d ctl: got 0x%05h expected 0x%05h (mask 0x%05h)", idx, a & mk, e & mk, mk);
      end
   endtask

   initial begin
      logic [5:0] fns[5];
      logic [2:0] acs[5];
      logic [5:0] limm[2];
      logic [2:0] lac[2];
      exp_t e;
      ctl_t v, m;
      bit   seen;

      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      acs = '{A_ADD, A_SUB, A_AND, A_OR, A_SLT};
      limm = '{ORI, ANDI};
      lac  = '{A_OR, A_AND};

      for (int i = 0; i < 3; i++) add(1, LW, 0, 0, 0, 0, A_ADD);
      for (int s = 0; s <= 4; s++) add(0, LW, 0, 0, s, 0, A_ADD);
      add(0, SW, 0, 0, 0, 0, A_ADD); add(0, SW, 0, 0, 1, 0, A_ADD);
      add(0, SW, 0, 0, 2, 0, A_ADD); add(0, SW, 0, 0, 5, 0, A_ADD);
      for (int k = 0; k < 5; k++) begin
         add(0, RT, fns[k], 0, 0, 0, A_ADD); add(0, RT, fns[k], 0, 1, 0, A_ADD);
         add(0, RT, fns[k], 0, 6, 0, acs[k]); add(0, RT, fns[k], 0, 7, 0, A_ADD);
      end
      for (int zz = 1; zz >= 0; zz--) begin
         add(0, BEQ, 0, 1'(zz), 0, 0, A_ADD); add(0, BEQ, 0, 1'(zz), 1, 0, A_ADD);
         add(0, BEQ, 0, 1'(zz), 8, 0, A_ADD);
      end
      add(0, ADDI, 0, 0, 0, 0, A_ADD); add(0, ADDI, 0, 0, 1, 0, A_ADD);
      add(0, ADDI, 0, 0, 9, 0, A_ADD); add(0, ADDI, 0, 0, 10, 0, A_ADD);
      add(0, JMP, 0, 1, 0, 0, A_ADD); add(0, JMP, 0, 1, 1, 0, A_ADD); add(0, JMP, 0, 1, 11, 0, A_ADD);
      add(0, BAD, 0, 0, 0, 0, A_ADD); add(0, BAD, 0, 0, 1, 1, A_ADD);
      add(0, RT, 6'b000111, 0, 0, 0, A_ADD); add(0, RT, 6'b000111, 0, 1, 0, A_ADD);
      add(0, RT, 6'b000111, 0, 6, 1, A_ADD);
      for (int k = 0; k < 2; k++) begin
         add(0, limm[k], 0, 0, 0, 0, A_ADD);
`ifdef MIPS_CTRL_LOGIC_IMM_EN
         add(0, limm[k], 0, 0, 1, 0, A_ADD); add(0, limm[k], 0, 0, 12, 0, lac[k]);
         add(0, limm[k], 0, 0, 10, 0, A_ADD);
`else
         add(0, limm[k], 0, 0, 1, 1, lac[k]);
`endif
      end
      add(0, LW, 0, 0, 0, 0, A_ADD); add(0, LW, 0, 0, 1, 0, A_ADD); add(0, LW, 0, 0, 2, 0, A_ADD);
      add(1, SW, 0, 0, 0, 0, A_ADD);
      add(0, SW, 0, 0, 0, 0, A_ADD); add(0, SW, 0, 0, 1, 0, A_ADD);
      add(0, SW, 0, 0, 2, 0, A_ADD); add(0, SW, 0, 0, 5, 0, A_ADD);
      add(0, JMP, 0, 0, 0, 0, A_ADD); add(0, JMP, 0, 0, 1, 0, A_ADD); add(0, JMP, 0, 0, 11, 0, A_ADD);

      foreach (rows[i]) begin
         rst = rows[i].rst;
         bus.opcode = rows[i].op;
         bus.funct  = rows[i].fn;
         bus.zero   = rows[i].z;
         model(rows[i], v, m);
         e.idx = i; e.st = rows[i].st; e.v = v; e.m = m;
         sb.push_back(e);
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("row%0d state", e.idx), 32'(bus.state_o), 32'(e.st));
         chk_ctl(e.idx, get_ctl(), e.v, e.m);
`ifndef MIPS_CTRL_LOGIC_IMM_EN
         chk($sformatf("row%0d srcb_not_zext", e.idx), 32'(bus.alu_src_b == 3'b100), 32'd0);
`endif
         @(posedge clk);
         #1;
      end

      // Asynchronous reset landing in MEMWB must kill the write-back at once.
      rst = 1'b0; bus.opcode = LW; bus.funct = '0; bus.zero = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (bus.state_o == 4'd4) seen = 1'b1;
      end
      chk("lw_reaches_memwb", 32'(seen), 32'd1);
      if (seen) begin
         chk("memwb_reg_write", 32'(bus.reg_write), 32'd1);
         rst = 1'b1;
         #1;
         chk("async_rst_state", 32'(bus.state_o), 32'd0);
         chk("async_rst_strobes", 32'({bus.reg_write, bus.mem_write, bus.ir_write, bus.pc_en}), 32'd0);
         @(posedge clk); #1;
         rst = 1'b0;
         @(negedge clk);
         chk("post_rst_fetch", 32'({bus.state_o, bus.ir_write, bus.pc_en, bus.reg_write}), 32'b0000_1_1_0);
         @(negedge clk);
         chk("post_rst_decode", 32'({bus.state_o, bus.reg_write, bus.mem_write}), 32'b0001_0_0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
